// File: rtl/scoreboard_rob.sv
// rtl/scoreboard_rob.sv - in-order issue, out-of-order writeback, in-order multi-commit scoreboard
// Entries live in a circular buffer; head is the oldest entry and tail is the next free slot.
package scoreboard_rob_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [7:0]  idx;
    logic [31:0] result;
  } decoder_t;
endpackage

module scoreboard_rob
  import scoreboard_rob_pkg::*;
#(
  parameter int Depth       = 4,
  parameter int WbPorts     = 2,
  parameter int CommitPorts = 1,
  localparam int Idx        = $clog2(Depth)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             issue_valid_i,
  input  decoder_t                         issue_instr_i,
  output logic                             issue_ready_o,
  output logic [Idx-1:0]                   issue_idx_o,
  input  logic [WbPorts-1:0]               wb_valid_i,
  input  logic [WbPorts-1:0][Idx-1:0]      wb_idx_i,
  input  logic [WbPorts-1:0][31:0]         wb_data_i,
  output logic [CommitPorts-1:0]           commit_valid_o,
  output decoder_t [CommitPorts-1:0]       commit_instr_o,
  input  logic [CommitPorts-1:0]           commit_ack_i,
  input  logic [4:0]                       rs1_i,
  input  logic [4:0]                       rs2_i,
  output logic                             rs1_busy_o,
  output logic                             rs2_busy_o,
  output logic                             rs1_fwd_valid_o,
  output logic                             rs2_fwd_valid_o,
  output logic [31:0]                      rs1_fwd_data_o,
  output logic [31:0]                      rs2_fwd_data_o
);

  logic [Depth-1:0] occupied;
  logic [Depth-1:0] done;
  decoder_t         entries [Depth];
  logic [Idx-1:0]   head;
  logic [Idx-1:0]   tail;
  logic [Idx:0]     count;
  logic [Idx:0]     retire_n;
  logic [Idx-1:0]   commit_slot [CommitPorts];
  logic             issue_fire;
  logic             prefix;
  logic             run;
  decoder_t         issue_entry;

  assign issue_ready_o = (count != (Idx+1)'(Depth)) && !flush_i;
  assign issue_idx_o   = tail;
  assign issue_fire    = issue_valid_i && issue_ready_o;

  always_comb begin
    issue_entry        = issue_instr_i;
    issue_entry.idx    = 8'(tail);
    issue_entry.result = '0;
  end

  // Commit ports expose a contiguous completed prefix; acks only count up to the first gap.
  always_comb begin
    retire_n = '0;
    prefix   = 1'b1;
    run      = 1'b1;
    for (int i = 0; i < CommitPorts; i++) begin
      commit_slot[i]    = head + Idx'(i);
      commit_valid_o[i] = prefix && !flush_i && occupied[commit_slot[i]] && done[commit_slot[i]];
      commit_instr_o[i] = entries[commit_slot[i]];
      prefix            = commit_valid_o[i];
      if (run && commit_ack_i[i] && commit_valid_o[i]) retire_n = retire_n + (Idx+1)'(1);
      else run = 1'b0;
    end
  end

  // Scanning oldest to youngest leaves the youngest matching producer selected.
  function automatic logic [33:0] lookup(input logic [4:0] rs);
    logic           hit;
    logic           fwd;
    logic [Idx-1:0] slot;
    logic [Idx-1:0] match;
    logic [31:0]    data;
    hit   = 1'b0;
    fwd   = 1'b0;
    match = '0;
    data  = '0;
    for (int k = 0; k < Depth; k++) begin
      slot = head + Idx'(k);
      if (occupied[slot] && entries[slot].rd == rs && rs != 5'd0) begin
        hit   = 1'b1;
        match = slot;
      end
    end
    if (hit && done[match]) begin
      fwd  = 1'b1;
      data = entries[match].result;
    end else if (hit) begin
      for (int p = 0; p < WbPorts; p++) begin
        if (wb_valid_i[p] && wb_idx_i[p] == match) begin
          fwd  = 1'b1;
          data = wb_data_i[p];
        end
      end
    end
    return {hit && !fwd, fwd, data};
  endfunction

  assign {rs1_busy_o, rs1_fwd_valid_o, rs1_fwd_data_o} = lookup(rs1_i);
  assign {rs2_busy_o, rs2_fwd_valid_o, rs2_fwd_data_o} = lookup(rs2_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupied <= '0;
      done     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int k = 0; k < Depth; k++) entries[k] <= '0;
    end else if (flush_i) begin
      occupied <= '0;
      done     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      for (int p = 0; p < WbPorts; p++) begin
        if (wb_valid_i[p] && occupied[wb_idx_i[p]]) begin
          done[wb_idx_i[p]]           <= 1'b1;
          entries[wb_idx_i[p]].result <= wb_data_i[p];
        end
      end
      for (int i = 0; i < CommitPorts; i++) begin
        if ((Idx+1)'(i) < retire_n) begin
          occupied[commit_slot[i]] <= 1'b0;
          done[commit_slot[i]]     <= 1'b0;
        end
      end
      if (issue_fire) begin
        entries[tail]  <= issue_entry;
        occupied[tail] <= 1'b1;
        done[tail]     <= 1'b0;
      end
      head  <= head + retire_n[Idx-1:0];
      tail  <= tail + Idx'(issue_fire);
      count <= count + (Idx+1)'(issue_fire) - retire_n;
    end
  end

endmodule

// File: tb/tb_scoreboard_rob.sv
// tb/tb_scoreboard_rob.sv - randomized bench for scoreboard_rob against a queue-based reference model
module tb_scoreboard_rob;
  import scoreboard_rob_pkg::*;

  localparam int D = 4;
  localparam int W = 2;
  localparam int C = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 flush, issue_valid, issue_ready;
  decoder_t             issue_instr;
  logic [1:0]           issue_idx;
  logic [W-1:0]         wb_valid;
  logic [W-1:0][1:0]    wb_idx;
  logic [W-1:0][31:0]   wb_data;
  logic [C-1:0]         commit_valid, commit_ack;
  decoder_t [C-1:0]     commit_instr;
  logic [4:0]           rs1, rs2;
  logic                 rs1_busy, rs2_busy, rs1_fv, rs2_fv;
  logic [31:0]          rs1_fd, rs2_fd;

  scoreboard_rob #(.Depth(D), .WbPorts(W), .CommitPorts(C)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_instr_i(issue_instr),
    .issue_ready_o(issue_ready), .issue_idx_o(issue_idx),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
    .commit_valid_o(commit_valid), .commit_instr_o(commit_instr), .commit_ack_i(commit_ack),
    .rs1_i(rs1), .rs2_i(rs2),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .rs1_fwd_valid_o(rs1_fv), .rs2_fwd_valid_o(rs2_fv),
    .rs1_fwd_data_o(rs1_fd), .rs2_fwd_data_o(rs2_fd)
  );

  typedef struct {
    decoder_t ins;
    bit       done;
  } ment_t;

  ment_t q[$];
  int    mhead = 0;
  int    total = 0;
  int    bad   = 0;

  bit                 s_iv, s_fl;
  decoder_t           s_ins;
  logic [W-1:0]       s_wv;
  logic [W-1:0][1:0]  s_wi;
  logic [W-1:0][31:0] s_wd;
  logic [C-1:0]       s_ack;
  logic [4:0]         s_r1, s_r2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic decoder_t mk(input logic [4:0] rd);
    decoder_t d;
    d.pc     = $urandom;
    d.op     = 8'($urandom);
    d.rd     = rd;
    d.rs1    = 5'($urandom);
    d.rs2    = 5'($urandom);
    d.idx    = 8'hFF;
    d.result = $urandom;
    return d;
  endfunction

  task automatic idle();
    s_iv = 0; s_fl = 0; s_ins = mk(5'd0);
    s_wv = '0; s_wi = '0; s_wd = '0; s_ack = '0; s_r1 = '0; s_r2 = '0;
  endtask

  task automatic drive();
    issue_valid = s_iv; issue_instr = s_ins; flush = s_fl;
    wb_valid = s_wv; wb_idx = s_wi; wb_data = s_wd; commit_ack = s_ack;
    rs1 = s_r1; rs2 = s_r2;
  endtask

  // Reference lookup: youngest queued producer of rs, else writeback in flight, else stall.
  function automatic void mlook(input logic [4:0] rs, output bit b, output bit fv, output logic [31:0] d);
    int m = -1;
    b = 0; fv = 0; d = '0;
    if (rs != 0) foreach (q[k]) if (q[k].ins.rd == rs) m = k;
    if (m >= 0) begin
      if (q[m].done) begin
        fv = 1; d = q[m].ins.result;
      end else begin
        for (int p = 0; p < W; p++)
          if (s_wv[p] && int'(s_wi[p]) == (mhead + m) % D) begin fv = 1; d = s_wd[p]; end
        b = !fv;
      end
    end
  endfunction

  task automatic step();
    int sz, n, tl;
    bit prev, run, v, b, fv;
    logic [31:0] d;
    ment_t e;
    @(negedge clk);
    drive();
    #1;
    sz = q.size();
    chk("issue_ready", issue_ready, (sz < D) && !s_fl);
    chk("issue_idx", issue_idx, (mhead + sz) % D);
    prev = 1; run = 1; n = 0;
    for (int i = 0; i < C; i++) begin
      v = !s_fl && i < sz && prev && q[i].done;
      prev = v;
      chk($sformatf("commit_valid%0d", i), commit_valid[i], v);
      if (v) chk($sformatf("commit_instr%0d", i), commit_instr[i], q[i].ins);
      if (run && s_ack[i] && v) n++;
      else run = 0;
    end
    mlook(s_r1, b, fv, d);
    chk("rs1_busy", rs1_busy, b);
    chk("rs1_fwd_valid", rs1_fv, fv);
    chk("rs1_fwd_data", rs1_fd, d);
    mlook(s_r2, b, fv, d);
    chk("rs2_busy", rs2_busy, b);
    chk("rs2_fwd_valid", rs2_fv, fv);
    chk("rs2_fwd_data", rs2_fd, d);
    if (s_fl) begin
      q.delete();
      mhead = 0;
    end else begin
      tl = (mhead + sz) % D;
      for (int p = 0; p < W; p++) begin
        int k = (int'(s_wi[p]) - mhead + D) % D;
        if (s_wv[p] && k < sz) begin
          e = q[k]; e.done = 1; e.ins.result = s_wd[p]; q[k] = e;
        end
      end
      repeat (n) void'(q.pop_front());
      mhead = (mhead + n) % D;
      if (s_iv && sz < D) begin
        e.ins = s_ins; e.ins.idx = 8'(tl); e.ins.result = '0; e.done = 0;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    s_r1 = 5'd3; s_r2 = 5'd7;
    step();

    // fill with rd 1..4, then a rejected fifth issue
    for (int r = 1; r <= 5; r++) begin
      idle(); s_iv = 1; s_ins = mk(5'(r)); s_ack = 2'b11; s_r1 = 5'(r); step();
    end

    // out-of-order writeback, port 1 beats port 0 on the same slot
    idle(); s_wv = 2'b01; s_wi[0] = 2'd2; s_wd[0] = 32'hA; s_ack = 2'b11; step();
    idle(); s_wv = 2'b11; s_wi[0] = 2'd0; s_wi[1] = 2'd0; s_wd[0] = 32'hB; s_wd[1] = 32'hC; s_r1 = 5'd1; step();
    idle(); s_wv = 2'b01; s_wi[0] = 2'd1; s_wd[0] = 32'hD; s_ack = 2'b10; step();
    idle(); s_ack = 2'b11; s_r1 = 5'd3; step();
    for (int i = 0; i < 3; i++) begin
      idle(); s_iv = 1; s_ins = mk(5'(i + 6)); s_ack = 2'b11;
      s_wv = 2'b01; s_wi[0] = 2'(i + 3); s_wd[0] = $urandom; step();
    end
    idle(); s_ack = 2'b11; step();
    idle(); s_ack = 2'b11; step();

    // forwarding from done entry vs. same-cycle writeback
    idle(); s_fl = 1; step();
    idle(); s_iv = 1; s_ins = mk(5'd5); step();
    idle(); s_iv = 1; s_ins = mk(5'd5); step();
    idle(); s_wv = 2'b01; s_wi[0] = 2'd0; s_wd[0] = 32'h11; step();
    idle(); s_r1 = 5'd5; step();
    idle(); s_r1 = 5'd5; s_wv = 2'b01; s_wi[0] = 2'd1; s_wd[0] = 32'h22; step();

    // flush against a same-cycle issue and writeback
    idle(); s_iv = 1; s_ins = mk(5'd5); step();
    idle(); s_fl = 1; s_iv = 1; s_ins = mk(5'd9); s_wv = 2'b01; s_wi[0] = 2'd2; s_wd[0] = 32'h33; s_ack = 2'b11; step();
    idle(); s_r1 = 5'd5; s_r2 = 5'd9; step();

    for (int t = 0; t < 3000; t++) begin
      s_iv  = ($urandom % 4) != 0;
      s_ins = mk(5'($urandom_range(0, 7)));
      s_fl  = ($urandom % 40) == 0;
      for (int p = 0; p < W; p++) begin
        s_wv[p] = ($urandom % 3) == 0;
        s_wi[p] = 2'($urandom);
        s_wd[p] = $urandom;
      end
      s_ack = C'($urandom);
      s_r1  = 5'($urandom_range(0, 7));
      s_r2  = 5'($urandom_range(0, 7));
      step();
    end

    // asynchronous reset in the middle of a cycle drops everything at once
    idle(); s_fl = 1; step();
    for (int i = 0; i < 3; i++) begin
      idle(); s_iv = 1; s_ins = mk(5'd3); step();
    end
    @(negedge clk);
    idle(); s_r1 = 5'd3; drive();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_issue_ready", issue_ready, 1'b1);
    chk("arst_issue_idx", issue_idx, 2'd0);
    chk("arst_commit_valid", commit_valid, 2'b00);
    chk("arst_rs1_busy", rs1_busy, 1'b0);
    chk("arst_rs1_fwd_valid", rs1_fv, 1'b0);
    chk("arst_rs1_fwd_data", rs1_fd, 32'd0);
    q.delete();
    mhead = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(); s_r1 = 5'd3; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
